// File: rtl/ram_arbiter.sv
// Two-to-one arbiter sharing one req/addr_ok/data_ok RAM port between the instruction and data ports.
// Optional macro RAM_ARB_ROUND_ROBIN_EN: round-robin on conflicts instead of fixed data-side priority.
//
// lock_q | meaning
// 0      | free: winner is picked fresh from the current requests
// 1      | held: address phase stalled, winner pinned to locked_id_q until accepted
`ifndef XLEN
`define XLEN 32
`endif

module ram_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int XLEN            = `XLEN
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              iram_req,
  input  logic              iram_write,
  input  logic [XLEN/8-1:0] iram_wstrb,
  input  logic [XLEN-1:0]   iram_addr,
  input  logic [XLEN-1:0]   iram_wdata,
  output logic              iram_addr_ok,
  output logic              iram_data_ok,
  output logic [XLEN-1:0]   iram_rdata,
  input  logic              dram_req,
  input  logic              dram_write,
  input  logic [XLEN/8-1:0] dram_wstrb,
  input  logic [XLEN-1:0]   dram_addr,
  input  logic [XLEN-1:0]   dram_wdata,
  output logic              dram_addr_ok,
  output logic              dram_data_ok,
  output logic [XLEN-1:0]   dram_rdata,
  output logic              ram_req,
  output logic              ram_write,
  output logic [XLEN/8-1:0] ram_wstrb,
  output logic [XLEN-1:0]   ram_addr,
  output logic [XLEN-1:0]   ram_wdata,
  input  logic              ram_addr_ok,
  input  logic              ram_data_ok,
  input  logic [XLEN-1:0]   ram_rdata
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] MAX_C  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_P = PW'(MAX_OUTSTANDING - 1);

  logic [CW-1:0]              count_q, count_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
  logic                       lock_q, lock_d, locked_id_q, locked_id_d;
  logic                       winner, accept, pop, head;
`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic                       rr_q, rr_d;
`endif

  // ID 0 = iram, 1 = dram
  always_comb begin
    winner = dram_req;
    if (lock_q) winner = locked_id_q;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    else if (iram_req && dram_req) winner = rr_q;
`endif
  end

  assign ram_req   = rst_b & (count_q < MAX_C) & (winner ? dram_req : iram_req);
  assign ram_write = ram_req & (winner ? dram_write : iram_write);
  assign ram_wstrb = ram_req ? (winner ? dram_wstrb : iram_wstrb) : '0;
  assign ram_addr  = ram_req ? (winner ? dram_addr  : iram_addr)  : '0;
  assign ram_wdata = ram_req ? (winner ? dram_wdata : iram_wdata) : '0;

  assign accept       = ram_req & ram_addr_ok;
  assign iram_addr_ok = accept & ~winner;
  assign dram_addr_ok = accept & winner;

  // A response with nothing outstanding (e.g. straggler after reset) is dropped.
  assign pop          = ram_data_ok & (count_q != '0);
  assign head         = fifo_q[rd_ptr_q];
  assign iram_data_ok = pop & ~head;
  assign dram_data_ok = pop & head;
  assign iram_rdata   = ram_rdata;
  assign dram_rdata   = ram_rdata;

  always_comb begin
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_d      = fifo_q;
    lock_d      = lock_q;
    locked_id_d = locked_id_q;
    if (accept) begin
      fifo_d[wr_ptr_q] = winner;
      wr_ptr_d = (wr_ptr_q == LAST_P) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = (rd_ptr_q == LAST_P) ? '0 : rd_ptr_q + PW'(1);
    case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (ram_req && !ram_addr_ok) begin
      lock_d      = 1'b1;
      locked_id_d = winner;
    end else if (accept) begin
      lock_d      = 1'b0;
    end
  end

`ifdef RAM_ARB_ROUND_ROBIN_EN
  assign rr_d = accept ? ~winner : rr_q;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_q      <= '0;
      lock_q      <= 1'b0;
      locked_id_q <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      rr_q        <= 1'b1;
`endif
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_q      <= fifo_d;
      lock_q      <= lock_d;
      locked_id_q <= locked_id_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      rr_q        <= rr_d;
`endif
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_b)
      assert (!(ram_data_ok && count_q == '0))
        else $warning("ram_arbiter: ram_data_ok with no outstanding transaction dropped");
  end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model of the arbitration and response ordering.
module tb_ram_arbiter;
  localparam int XLEN = 32;
  localparam int MAX  = 2;
`ifdef RAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_b = 1'b1;
  logic iram_req, iram_write, dram_req, dram_write;
  logic [XLEN/8-1:0] iram_wstrb, dram_wstrb, ram_wstrb;
  logic [XLEN-1:0] iram_addr, iram_wdata, dram_addr, dram_wdata;
  logic iram_addr_ok, iram_data_ok, dram_addr_ok, dram_data_ok;
  logic [XLEN-1:0] iram_rdata, dram_rdata;
  logic ram_req, ram_write, ram_addr_ok, ram_data_ok;
  logic [XLEN-1:0] ram_addr, ram_wdata, ram_rdata;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.MAX_OUTSTANDING(MAX), .XLEN(XLEN)) dut (
    .clk(clk), .rst_b(rst_b),
    .iram_req(iram_req), .iram_write(iram_write), .iram_wstrb(iram_wstrb),
    .iram_addr(iram_addr), .iram_wdata(iram_wdata),
    .iram_addr_ok(iram_addr_ok), .iram_data_ok(iram_data_ok), .iram_rdata(iram_rdata),
    .dram_req(dram_req), .dram_write(dram_write), .dram_wstrb(dram_wstrb),
    .dram_addr(dram_addr), .dram_wdata(dram_wdata),
    .dram_addr_ok(dram_addr_ok), .dram_data_ok(dram_data_ok), .dram_rdata(dram_rdata),
    .ram_req(ram_req), .ram_write(ram_write), .ram_wstrb(ram_wstrb),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_addr_ok(ram_addr_ok), .ram_data_ok(ram_data_ok), .ram_rdata(ram_rdata)
  );

  task automatic idle_inputs();
    iram_req = 0; iram_write = 0; iram_wstrb = '0; iram_addr = '0; iram_wdata = '0;
    dram_req = 0; dram_write = 0; dram_wstrb = '0; dram_addr = '0; dram_wdata = '0;
    ram_addr_ok = 0; ram_data_ok = 0; ram_rdata = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_b = 0;
    tick(); tick();
    rst_b = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst_b = 0;
    #2;
    n_cmp++;
    if ({ram_req, ram_write, ram_wstrb, ram_addr, ram_wdata, iram_addr_ok, iram_data_ok,
         dram_addr_ok, dram_data_ok, iram_rdata, dram_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got ram_req=%b ram_addr=%h, want all zero", ram_req, ram_addr);
    end
    tick(); tick();
    rst_b = 1; #2;
    n_cmp++;
    if ({ram_req, ram_write, ram_wstrb, ram_addr, ram_wdata, iram_addr_ok, iram_data_ok,
         dram_addr_ok, dram_data_ok} !== '0) begin
      n_fail++; $display("FAIL post_reset_idle: got ram_req=%b ram_addr=%h, want all zero", ram_req, ram_addr);
    end
    tick();
  endtask

  task automatic test_single_iram();
    iram_req = 1; iram_addr = 32'h100; ram_addr_ok = 1; #2;
    n_cmp++;
    if ({ram_req, iram_addr_ok, dram_addr_ok, ram_addr} !== {3'b110, 32'h100}) begin
      n_fail++; $display("FAIL t1_accept: got req/iok/dok=%b%b%b addr=%h want 110 addr=00000100",
                         ram_req, iram_addr_ok, dram_addr_ok, ram_addr);
    end
    tick();
    iram_req = 0; iram_addr = '0; ram_addr_ok = 0; #2;
    n_cmp++;
    if ({iram_data_ok, dram_data_ok} !== 2'b00) begin
      n_fail++; $display("FAIL t1_no_early_resp: got %b%b want 00", iram_data_ok, dram_data_ok);
    end
    tick();
    ram_data_ok = 1; ram_rdata = 32'h13; #2;
    n_cmp++;
    if ({iram_data_ok, dram_data_ok, iram_rdata} !== {2'b10, 32'h13}) begin
      n_fail++; $display("FAIL t1_resp: got i/d=%b%b rdata=%h want 10 rdata=00000013",
                         iram_data_ok, dram_data_ok, iram_rdata);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_conflict();
    iram_req = 1; iram_addr = 32'h0;
    dram_req = 1; dram_addr = 32'h2000; dram_write = 1; dram_wstrb = 4'hF; dram_wdata = 32'hDEADBEEF;
    ram_addr_ok = 1; #2;
    n_cmp++;
    if ({ram_req, ram_write, ram_wstrb, iram_addr_ok, dram_addr_ok, ram_addr, ram_wdata} !==
        {1'b1, 1'b1, 4'hF, 1'b0, 1'b1, 32'h2000, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL t2_dram_first: got iok=%b dok=%b addr=%h wstrb=%h want dram addr=00002000 wstrb=f",
                         iram_addr_ok, dram_addr_ok, ram_addr, ram_wstrb);
    end
    tick();
    dram_req = 0; dram_write = 0; dram_wstrb = '0; dram_addr = '0; dram_wdata = '0; #2;
    n_cmp++;
    if ({ram_req, ram_write, iram_addr_ok, dram_addr_ok, ram_addr} !== {4'b1010, 32'h0}) begin
      n_fail++; $display("FAIL t2_iram_next: got iok=%b dok=%b addr=%h want iram addr=0",
                         iram_addr_ok, dram_addr_ok, ram_addr);
    end
    tick();
    iram_req = 0; ram_addr_ok = 0; ram_data_ok = 1; ram_rdata = 32'hAAAA; #2;
    n_cmp++;
    if ({iram_data_ok, dram_data_ok, dram_rdata} !== {2'b01, 32'hAAAA}) begin
      n_fail++; $display("FAIL t2_resp_dram: got i/d=%b%b rdata=%h want 01 rdata=0000aaaa",
                         iram_data_ok, dram_data_ok, dram_rdata);
    end
    tick();
    ram_rdata = 32'h5555; #2;
    n_cmp++;
    if ({iram_data_ok, dram_data_ok} !== 2'b10) begin
      n_fail++; $display("FAIL t2_resp_iram: got i/d=%b%b want 10", iram_data_ok, dram_data_ok);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_lock();
    iram_req = 1; iram_addr = 32'h40;
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) begin dram_req = 1; dram_addr = 32'h80; end
      #2;
      n_cmp++;
      if ({ram_req, iram_addr_ok, dram_addr_ok, ram_addr} !== {3'b100, 32'h40}) begin
        n_fail++; $display("FAIL t3_stall_c%0d: got req=%b iok=%b dok=%b addr=%h want 100 addr=00000040",
                           c, ram_req, iram_addr_ok, dram_addr_ok, ram_addr);
      end
      tick();
    end
    ram_addr_ok = 1; #2;
    n_cmp++;
    if ({iram_addr_ok, dram_addr_ok, ram_addr} !== {2'b10, 32'h40}) begin
      n_fail++; $display("FAIL t3_locked_accept: got iok=%b dok=%b addr=%h want iram addr=00000040",
                         iram_addr_ok, dram_addr_ok, ram_addr);
    end
    tick();
    iram_req = 0; iram_addr = '0; #2;
    n_cmp++;
    if ({iram_addr_ok, dram_addr_ok, ram_addr} !== {2'b01, 32'h80}) begin
      n_fail++; $display("FAIL t3_dram_after: got iok=%b dok=%b addr=%h want dram addr=00000080",
                         iram_addr_ok, dram_addr_ok, ram_addr);
    end
    tick();
    dram_req = 0; ram_addr_ok = 0; ram_data_ok = 1; #2;
    n_cmp++;
    if ({iram_data_ok, dram_data_ok} !== 2'b10) begin
      n_fail++; $display("FAIL t3_resp0: got %b%b want 10", iram_data_ok, dram_data_ok);
    end
    tick(); #2;
    n_cmp++;
    if ({iram_data_ok, dram_data_ok} !== 2'b01) begin
      n_fail++; $display("FAIL t3_resp1: got %b%b want 01", iram_data_ok, dram_data_ok);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_full();
    iram_req = 1; ram_addr_ok = 1;
    for (int i = 0; i < 2; i++) begin
      iram_addr = 32'h200 + 32'(4 * i); #2;
      n_cmp++;
      if ({iram_addr_ok, ram_addr} !== {1'b1, iram_addr}) begin
        n_fail++; $display("FAIL t4_accept%0d: got iok=%b addr=%h want 1 addr=%h", i, iram_addr_ok, ram_addr, iram_addr);
      end
      tick();
    end
    iram_addr = 32'h208; #2;
    n_cmp++;
    if ({ram_req, iram_addr_ok} !== 2'b00) begin
      n_fail++; $display("FAIL t4_full_block: got req=%b iok=%b want 00", ram_req, iram_addr_ok);
    end
    tick();
    ram_data_ok = 1; #2;
    n_cmp++;
    if ({ram_req, iram_addr_ok, iram_data_ok} !== 3'b001) begin
      n_fail++; $display("FAIL t4_full_pop: got req=%b iok=%b idok=%b want 001", ram_req, iram_addr_ok, iram_data_ok);
    end
    tick();
    ram_data_ok = 0; #2;
    n_cmp++;
    if ({ram_req, iram_addr_ok, ram_addr} !== {2'b11, 32'h208}) begin
      n_fail++; $display("FAIL t4_third: got req=%b iok=%b addr=%h want 11 addr=00000208", ram_req, iram_addr_ok, ram_addr);
    end
    tick();
    iram_req = 0; ram_addr_ok = 0; ram_data_ok = 1;
    for (int i = 0; i < 2; i++) begin
      #2;
      n_cmp++;
      if ({iram_data_ok, dram_data_ok} !== 2'b10) begin
        n_fail++; $display("FAIL t4_drain%0d: got %b%b want 10", i, iram_data_ok, dram_data_ok);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_empty_and_reset();
    ram_data_ok = 1; #2;
    n_cmp++;
    if ({iram_data_ok, dram_data_ok} !== 2'b00) begin
      n_fail++; $display("FAIL t5_empty_resp: got %b%b want 00", iram_data_ok, dram_data_ok);
    end
    tick();
    ram_data_ok = 0; iram_req = 1; iram_addr = 32'h500; ram_addr_ok = 1;
    for (int i = 0; i < 2; i++) begin
      #2;
      n_cmp++;
      if (iram_addr_ok !== 1'b1) begin
        n_fail++; $display("FAIL t5_fill%0d: got iok=%b want 1", i, iram_addr_ok);
      end
      tick();
    end
    #2;
    n_cmp++;
    if (ram_req !== 1'b0) begin
      n_fail++; $display("FAIL t5_full_check: got req=%b want 0", ram_req);
    end
    rst_b = 0; #2;
    n_cmp++;
    if ({ram_req, ram_write, ram_wstrb, ram_addr, ram_wdata, iram_addr_ok, iram_data_ok,
         dram_addr_ok, dram_data_ok} !== '0) begin
      n_fail++; $display("FAIL t5_reset_outputs: got req=%b addr=%h iok=%b want all zero", ram_req, ram_addr, iram_addr_ok);
    end
    tick();
    rst_b = 1; iram_req = 0; iram_addr = '0; ram_addr_ok = 0; ram_data_ok = 1; #2;
    n_cmp++;
    if ({iram_data_ok, dram_data_ok} !== 2'b00) begin
      n_fail++; $display("FAIL t5_late_resp: got %b%b want 00", iram_data_ok, dram_data_ok);
    end
    tick();
    ram_data_ok = 0; iram_req = 1; iram_addr = 32'h300; #2;
    tick();
    rst_b = 0; tick(); rst_b = 1;
    dram_req = 1; dram_addr = 32'h400; ram_addr_ok = 1; #2;
    n_cmp++;
    if ({iram_addr_ok, dram_addr_ok, ram_addr} !== {2'b01, 32'h400}) begin
      n_fail++; $display("FAIL t5_lock_cleared: got iok=%b dok=%b addr=%h want dram addr=00000400",
                         iram_addr_ok, dram_addr_ok, ram_addr);
    end
    tick();
    idle_inputs();
    do_reset();
  endtask

  task automatic test_round_robin();
    bit prev_w;
    bit exp_w;
    do_reset();
    iram_req = 1; iram_addr = 32'h1000; dram_req = 1; dram_addr = 32'h2000; ram_addr_ok = 1;
    prev_w = 0;
    for (int k = 0; k < 6; k++) begin
      ram_data_ok = (k > 0);
      exp_w = RR ? ((k % 2) == 0) : 1'b1;
      #2;
      n_cmp++;
      if ({iram_addr_ok, dram_addr_ok} !== {~exp_w, exp_w}) begin
        n_fail++; $display("FAIL t6_grant%0d: got iok=%b dok=%b want dram=%b", k, iram_addr_ok, dram_addr_ok, exp_w);
      end
      if (k > 0) begin
        n_cmp++;
        if ({iram_data_ok, dram_data_ok} !== {~prev_w, prev_w}) begin
          n_fail++; $display("FAIL t6_resp%0d: got idok=%b ddok=%b want dram=%b", k, iram_data_ok, dram_data_ok, prev_w);
        end
      end
      prev_w = exp_w;
      tick();
    end
    idle_inputs();
    do_reset();
  endtask

  task automatic test_random(int ncyc);
    int q[$];
    int owner;
    bit rr, hold_i, hold_d, elig, e_req, acc, pop;
    int win;
    logic [105:0] act, exp_v;
    logic [XLEN/8-1:0] e_wstrb;
    logic [XLEN-1:0] e_addr, e_wdata;
    logic e_write;
    owner = -1; rr = 1; hold_i = 0; hold_d = 0;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      if (!hold_i) begin
        iram_req = ($urandom_range(0, 2) != 0); iram_write = $urandom_range(0, 1);
        iram_wstrb = 4'($urandom); iram_addr = $urandom; iram_wdata = $urandom;
      end
      if (!hold_d) begin
        dram_req = ($urandom_range(0, 2) != 0); dram_write = $urandom_range(0, 1);
        dram_wstrb = 4'($urandom); dram_addr = $urandom; dram_wdata = $urandom;
      end
      ram_addr_ok = $urandom_range(0, 1);
      ram_data_ok = (q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      ram_rdata = $urandom;
      if (owner >= 0) win = owner;
      else if (iram_req && dram_req) win = RR ? int'(rr) : 1;
      else win = dram_req ? 1 : 0;
      elig  = q.size() < MAX;
      e_req = elig && (win == 1 ? dram_req : iram_req);
      e_write = e_req && (win == 1 ? dram_write : iram_write);
      e_wstrb = e_req ? (win == 1 ? dram_wstrb : iram_wstrb) : '0;
      e_addr  = e_req ? (win == 1 ? dram_addr : iram_addr) : '0;
      e_wdata = e_req ? (win == 1 ? dram_wdata : iram_wdata) : '0;
      acc = e_req && ram_addr_ok;
      pop = ram_data_ok && q.size() > 0;
      exp_v = {e_req, e_write, e_wstrb, e_addr, e_wdata, acc && win == 0, acc && win == 1,
               pop && q[0] == 0, pop && q[0] == 1, ram_rdata};
      #2;
      act = {ram_req, ram_write, ram_wstrb, ram_addr, ram_wdata, iram_addr_ok, dram_addr_ok,
             iram_data_ok, dram_data_ok, iram_rdata};
      n_cmp++;
      if (act !== exp_v) begin
        n_fail++; $display("FAIL rand_c%0d: got %h want %h", c, act, exp_v);
      end
      if (pop) void'(q.pop_front());
      if (acc) begin q.push_back(win); owner = -1; rr = (win == 0); end
      else if (e_req) owner = win;
      hold_i = iram_req && !(acc && win == 0);
      hold_d = dram_req && !(acc && win == 1);
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_iram();
    test_conflict();
    test_lock();
    test_full();
    test_empty_and_reset();
    test_round_robin();
    test_random(600);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-to-one arbiter that shares a single unified RAM port between the core's instruction port (iram_*) and data port (dram_*).
- All three ports use the same split req/addr_ok/data_ok protocol.
- Grant is chosen when a request is presented and held until the address phase is accepted.
- An in-order ID FIFO records which requester owns each outstanding transaction, so every data_ok/rdata is routed back to the correct requester.
- Sits between core and the memory wrapper on single-port-RAM targets.

Parameters:
MAX_OUTSTANDING, 2, depth of the response-order FIFO (≥1); caps accepted-but-unanswered transactions.
XLEN, `XLEN, data/address width.

Ports:
clk  input  1  clock
rst_b  input  1  asynchronous active-low reset
iram_req  input  1  instruction-side request
iram_write  input  1  instruction-side write
iram_wstrb  input  XLEN/8  instruction-side byte strobes
iram_addr  input  XLEN  instruction-side address
iram_wdata  input  XLEN  instruction-side write data
iram_addr_ok  output  1  instruction request accepted
iram_data_ok  output  1  instruction response valid
iram_rdata  output  XLEN  instruction read data
dram_req / dram_write / dram_wstrb / dram_addr / dram_wdata  input  1/1/XLEN/8/XLEN/XLEN  data-side request, same meaning
dram_addr_ok  output  1  data request accepted
dram_data_ok  output  1  data response valid
dram_rdata  output  XLEN  data read data
ram_req  output  1  shared RAM request
ram_write  output  1  shared write
ram_wstrb  output  XLEN/8  shared strobes
ram_addr  output  XLEN  shared address
ram_wdata  output  XLEN  shared write data
ram_addr_ok  input  1  RAM accepted request
ram_data_ok  input  1  RAM response valid
ram_rdata  input  XLEN  RAM read data

Behaviour:
- Clock, reset: one clock, clk. Reset is asynchronous, active-low (rst_b).
- Reset state:
  - lock=0, FIFO count=0, rr pointer selects dram.
  - All outputs 0 while rst_b low and on the first cycle after release with no request.
  - Reset mid-transaction drops all outstanding IDs. Late ram_data_ok after reset is treated as the empty case.
- Arbitration (combinational, zero-cycle latency):
  - Eligible only when count < MAX_OUTSTANDING.
  - Without lock: winner = dram if dram_req, else iram (see Optional Feature).
  - ram_req = eligible & winner's req.
  - ram_write/wstrb/addr/wdata are muxed from the winner; all zero when ram_req=0.
- Lock:
  - If ram_req=1 and ram_addr_ok=0, the next cycle sets lock=1 and locked_id=winner.
  - While locked, the winner is forced to locked_id even if the other requester asserts. Requesters must hold req and payload until addr_ok.
  - Lock clears on the accept cycle.
- Accept:
  - x_addr_ok = ram_addr_ok & ram_req & (winner==x).
  - On accept, push winner ID (0=iram, 1=dram) into the FIFO.
- Response:
  - On ram_data_ok with count>0, pop the head. Head==0 drives iram_data_ok, head==1 drives dram_data_ok; exactly one pulses, same cycle (combinational).
  - iram_rdata = dram_rdata = ram_rdata (unqualified).
  - ram_data_ok with count==0 is ignored: no pop, no data_ok. Assertion only in simulation.
- Push and pop in the same cycle: count unchanged, both operations occur.
- Full: when count==MAX_OUTSTANDING, ram_req=0, so no push can occur. Full blocks new requests even if a pop happens the same cycle; the request goes out next cycle.
- Counter and pointers wrap modulo MAX_OUTSTANDING. Count width is clog2(MAX_OUTSTANDING+1).
- A requester may issue back-to-back accepted requests every cycle while not full.

Optional Feature:
- Macro: RAM_ARB_ROUND_ROBIN_EN.
- Defined:
  - Unlocked winner on a conflict (both req) = rr pointer.
  - Pointer flips to the other requester after each accept from the current one. It is updated only on accept.
  - A single requester always wins regardless of the pointer.
- Undefined: fixed priority, dram always beats iram; no pointer register.

Test Plan:
1. Reset release, iram_req=1 addr=0x100, ram_addr_ok=1 → ram_addr=0x100, iram_addr_ok=1 same cycle; ram_data_ok with rdata=0x13 two cycles later → iram_data_ok=1, iram_rdata=0x13, dram_data_ok=0.
2. Both req same cycle, iram addr 0x0, dram addr 0x2000 write wstrb=0xF, no round-robin → dram accepted first; iram accepted next cycle; responses returned in order route dram then iram.
3. iram_req at 0x40 with ram_addr_ok=0 for 3 cycles, dram_req rises on cycle 2 → ram_addr stays 0x40 until accept; dram accepted only on the following cycle.
4. MAX_OUTSTANDING=2: three iram requests, ram_addr_ok=1, no data_ok → first two accepted, third ram_req=0; one ram_data_ok → third accepted on the next cycle.
5. ram_data_ok pulse with FIFO empty → no data_ok to either side, count stays 0; rst_b pulse with 2 outstanding → count=0, lock=0, all outputs 0.
6. RAM_ARB_ROUND_ROBIN_EN defined, both req continuously → accepts alternate dram, iram, dram, iram.
